iter_alu: RTL
=============

# iter_alu

Parametrised, handshaked ALU for the tile datapath. It extends the original 8-bit opcode set with a multi-cycle shift-add multiplier and a restoring divider that return full-width results (product high half, remainder) plus status flags. Operands enter on a valid/ready request channel; results leave on a valid/ready response channel. The block sits between the pin-unpacking logic and the output register bank.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  3  opcode, sampled on accept.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts the response.
- res_lo  out  WIDTH  primary result: sum, difference, logic result, product low half, or quotient.
- res_hi  out  WIDTH  product high half or remainder; 0 for other ops.
- flag_z  out  1  res_lo == 0.
- flag_c  out  1  add carry-out, sub borrow (a < b), or mul overflow (res_hi != 0); 0 otherwise.
- flag_err  out  1  divide by zero or illegal opcode.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 DIV, 100 OR, 101 MUL, 110 XOR, 111 illegal.
- All operands are unsigned. ADD/SUB wrap modulo 2^WIDTH, with the carry/borrow reported in flag_c.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op, a and b.
    - MUL, or DIV with b≠0 → BUSY, with cnt loaded to WIDTH.
    - All other ops (including DIV with b=0) → DONE, with the result computed combinationally from the latched operands.
  - BUSY: one iteration per cycle; cnt decrements. At cnt==1 the final iteration completes → DONE.
  - DONE: out_valid=1 and outputs stable. On out_ready → IDLE.
- MUL: shift-add with a 2·WIDTH-bit accumulator. res_hi:res_lo = a·b.
- DIV: restoring, one quotient bit per cycle, MSB first. res_lo=quotient, res_hi=remainder.
- DIV with b=0: res_lo=all ones, res_hi=a, flag_err=1. No iteration is performed.
- Illegal op 111: res_lo=res_hi=0, flag_z=1, flag_err=1.
- Inputs are ignored outside IDLE. Operand changes while BUSY or DONE have no effect.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, res_lo=res_hi=0, all flags 0, cnt=0.
- rst mid-operation (BUSY or DONE): the pending operation is discarded and the block returns to the reset values on the next edge. No response is produced.

## Timing
- Accept edge = T, the edge where in_valid && in_ready.
- Single-cycle ops and DIV with b=0: out_valid high from T+1.
- MUL and DIV with b≠0: out_valid high from T+WIDTH. For WIDTH=8 that is 8 cycles of BUSY, the first ending at T+1.
- The response is held until the edge where out_valid && out_ready. in_ready rises the cycle after that edge.
- There is no overlap of request and response.
- Back-to-back maximum throughput: one single-cycle op every 2 cycles; one mul/div every WIDTH+1 cycles.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- res_* and flag_* are registered. They change only on the edge entering DONE or on reset.

## Structure
- Package iter_alu_pkg holds:
  - opcode localparams (OP_ADD … OP_ILL);
  - the state enum (IDLE, BUSY, DONE);
  - a function computing the single-cycle result and flags.
- Sub-module iter_muldiv holds the shared WIDTH-parametrised accumulator/shift datapath and the iteration counter. Its ports: start, is_div, a, b, busy, done, hi, lo.
- The iter_alu top level contains the FSM, the handshake logic and the output registers.

## Test plan
- WIDTH=8, ADD a=200 b=100 → at T+1: res_lo=44, flag_c=1, flag_z=0, flag_err=0. SUB a=5 b=5 → res_lo=0, flag_z=1, flag_c=0.
- MUL a=200 b=3 → out_valid exactly at T+8: res_hi=2, res_lo=88, flag_c=1. Operands toggled randomly during BUSY must not change the result.
- DIV a=200 b=7 → at T+8: res_lo=28, res_hi=4. DIV a=9 b=0 → at T+1: res_lo=255, res_hi=9, flag_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable and in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready.
- rst asserted at T+4 of a MUL → next cycle out_valid=0, in_ready=1, all outputs 0; a fresh ADD 1+1 then returns res_lo=2.
- Op 111 → res_lo=res_hi=0, flag_z=1, flag_err=1. Repeat ADD/MUL/DIV at WIDTH=4 and WIDTH=16 against a reference model (e.g. WIDTH=16: MUL 65535·65535 → res_hi=65534, res_lo=1).

Source files
------------

// File: rtl/iter_alu_pkg.sv
// -----------------------------------------------------------------------------
// iter_alu_pkg
//   Shared definitions for the iterative ALU:
//     - 3-bit opcode encodings (OP_ADD .. OP_ILL)
//     - FSM state enum used by the iter_alu top level
//     - alu_res_t result/flag bundle and alu_single(), the combinational
//       evaluator for every opcode that completes in a single cycle
//       (ADD, SUB, AND, OR, XOR, DIV by zero, illegal).
//   alu_single() works on MAX_W-bit containers and masks to the caller's
//   width, so one function serves every WIDTH the top is built with
//   (2 <= WIDTH < MAX_W).
// -----------------------------------------------------------------------------
package iter_alu_pkg;

  // Container width for the width-agnostic helper function.
  localparam int MAX_W = 64;

  // Opcode encodings.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // Request/response FSM: accept in IDLE, iterate in BUSY, hold result in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result bundle produced by the single-cycle evaluator.
  typedef struct packed {
    logic [MAX_W-1:0] lo;
    logic [MAX_W-1:0] hi;
    logic             z;
    logic             c;
    logic             err;
  } alu_res_t;

  // True when the request needs the shared shift/add datapath.
  // Divide by zero short-circuits to a single-cycle error response.
  function automatic logic is_iter(input logic [2:0] op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

  // Single-cycle result. Operands must already be zero-extended from
  // 'width' bits. The MUL and non-zero DIV branches are never selected by
  // the caller (those go through iter_muldiv); their content is don't-care.
  function automatic alu_res_t alu_single(input logic [2:0]       op,
                                          input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input int               width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W:0]   sum;
    alu_res_t         r;
    r    = '0;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    sum  = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        r.lo = sum[MAX_W-1:0] & mask;
        // Operands fit in 'width' bits, so anything above is exactly the carry.
        r.c  = (sum >> width) != '0;
      end
      OP_SUB: begin
        r.lo = (a - b) & mask;
        r.c  = (a < b);
      end
      OP_AND: r.lo = a & b;
      OP_OR:  r.lo = a | b;
      OP_XOR: r.lo = a ^ b;
      OP_DIV: begin
        // Only reached for b == 0: saturated quotient, dividend as remainder.
        r.lo  = mask;
        r.hi  = a;
        r.err = 1'b1;
      end
      OP_MUL: r.lo = '0;
      default: r.err = 1'b1;  // OP_ILL
    endcase
    r.z = (r.lo == '0);
    return r;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// -----------------------------------------------------------------------------
// iter_muldiv
//   Shared multi-cycle datapath for MUL (shift-add) and DIV (restoring,
//   MSB first). One result bit per clock, WIDTH iterations per operation.
//
//   The 2*WIDTH accumulator is split into hi_q:lo_q and reused by both ops:
//     MUL : hi_q = partial product, lo_q = multiplier (shifted out LSB first,
//           product low bits shifted in from the top), d_q = multiplicand.
//     DIV : hi_q = partial remainder, lo_q = dividend (shifted out MSB first,
//           quotient bits shifted in at the bottom), d_q = divisor.
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     start         load operands and begin WIDTH iterations (ignored-free:
//                   the caller only pulses it while this block is idle)
//     is_div        1 = divide, 0 = multiply (sampled with start)
//     a, b          operands (sampled with start)
//     busy          iterations outstanding
//     done          the iteration performed on the coming edge is the last
//     hi, lo        accumulator value after the current iteration; equals the
//                   final {product high, product low} / {remainder, quotient}
//                   whenever done is high
// -----------------------------------------------------------------------------
module iter_muldiv
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, d_q;
  logic             div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial_sh;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ok;
  logic [WIDTH-1:0] hi_n, lo_n;

  // One iteration of whichever operation is in flight.
  // NOTE: every variable assigned here gets a value on every path (defaults
  // or complete if/else), otherwise synthesis would infer a latch.
  always_comb begin
    // MUL: add the multiplicand when the current multiplier LSB is set,
    // then shift the (WIDTH+1)-bit sum and the multiplier right together.
    add_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);

    // DIV: bring the next dividend bit into the remainder and trial-subtract.
    // The remainder is always below the divisor, so a non-negative difference
    // fits in WIDTH bits and the top bit of the (WIDTH+1)-bit difference is
    // set exactly when the subtraction underflowed.
    trial_sh   = {hi_q, lo_q[WIDTH-1]};
    trial_diff = trial_sh - {1'b0, d_q};
    trial_ok   = ~trial_diff[WIDTH];

    if (div_q) begin
      hi_n = trial_ok ? trial_diff[WIDTH-1:0] : trial_sh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], trial_ok};
    end else begin
      hi_n = add_sum[WIDTH:1];
      lo_n = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well; they are few and a
      // defined value keeps hi/lo deterministic straight out of reset.
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      d_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      cnt_q <= CNT_W'(WIDTH);
      hi_q  <= '0;
      lo_q  <= is_div ? a : b;
      d_q   <= is_div ? b : a;
      div_q <= is_div;
    end else if (busy) begin
      cnt_q <= cnt_q - CNT_W'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign hi   = hi_n;
  assign lo   = lo_n;

endmodule

// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu
//   Handshaked ALU: ADD/SUB/AND/OR/XOR complete in one cycle, MUL and DIV
//   iterate WIDTH cycles in iter_muldiv and return full-width results.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   request handshake; in_ready is high only in IDLE
//     op, a, b              opcode and unsigned operands, sampled on accept
//     out_valid / out_ready response handshake; out_valid is high only in DONE
//     res_lo                sum / difference / logic result / product low /
//                           quotient
//     res_hi                product high / remainder, 0 otherwise
//     flag_z                res_lo == 0
//     flag_c                ADD carry, SUB borrow, MUL overflow (res_hi != 0)
//     flag_err              divide by zero or illegal opcode
//
//   in_ready / out_valid decode the registered state only. Result and flag
//   registers load on the edge entering DONE and hold until the next one.
// -----------------------------------------------------------------------------
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 8  // operand width, 2 <= WIDTH < MAX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_err
);

  state_t     state_q, state_d;
  logic [2:0] op_q;

  logic       accept;
  logic       iter_req;
  alu_res_t   single_r;

  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign accept   = in_valid && in_ready;
  assign iter_req = is_iter(op, (b == '0));
  assign md_start = accept && iter_req;

  // Single-cycle result, evaluated from the live inputs and captured on the
  // accept edge together with op.
  assign single_r = alu_single(op, MAX_W'(a), MAX_W'(b), WIDTH);

  if (WIDTH < MAX_W) begin : g_unused
    logic unused_single_hi_bits;
    assign unused_single_hi_bits = ^{single_r.lo[MAX_W-1:WIDTH],
                                     single_r.hi[MAX_W-1:WIDTH]};
  end

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = iter_req ? BUSY : DONE;
      BUSY: if (md_done)   state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure state decode, no path from in_valid / out_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Result and flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      res_lo   <= '0;
      res_hi   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_err <= 1'b0;
    end else if (accept && !iter_req) begin
      res_lo   <= single_r.lo[WIDTH-1:0];
      res_hi   <= single_r.hi[WIDTH-1:0];
      flag_z   <= single_r.z;
      flag_c   <= single_r.c;
      flag_err <= single_r.err;
    end else if ((state_q == BUSY) && md_done) begin
      // md_hi/md_lo already carry the final iteration's result on this edge.
      res_lo   <= md_lo;
      res_hi   <= md_hi;
      flag_z   <= (md_lo == '0);
      flag_c   <= (op_q == OP_MUL) && (md_hi != '0);
      flag_err <= 1'b0;
    end
  end

  // md_busy is implied by state_q == BUSY; kept for observability.
  logic unused_md_busy;
  assign unused_md_busy = md_busy;

endmodule
